// File: rtl/pwm_cmd_ctrl_if.sv
// rtl/pwm_cmd_ctrl_if.sv - byte receive, duty bank and response handshake bundle for pwm_cmd_ctrl
interface pwm_cmd_ctrl_if #(
  parameter int NUM_CH = 4
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [8*NUM_CH-1:0] duty;
  logic [NUM_CH-1:0]   duty_update;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [7:0]          err_count;
  logic                busy;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  duty, duty_update, tx_data, tx_valid, err_count, busy
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output duty, duty_update, tx_data, tx_valid, err_count, busy
  );
endinterface

// File: rtl/pwm_cmd_ctrl.sv
// rtl/pwm_cmd_ctrl.sv - framed UART command parser driving a bank of 8-bit PWM duty registers
module pwm_cmd_ctrl #(
  parameter int         CLK_FREQ   = 72_000_000,
  parameter int         NUM_CH     = 4,
  parameter logic [7:0] DUTY_INIT  = 8'h40,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         TIMEOUT_US = 1000
) (
  input logic          CLK,
  input logic          RST,
  pwm_cmd_ctrl_if.slave bus
);
  localparam int               TIMEOUT_CYC = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
  localparam int               CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       ACK         = 8'h06;
  localparam logic [7:0]       NAK         = 8'h15;

  typedef enum logic [2:0] {IDLE, GET_CMD, GET_ARG, GET_CHK, EXEC, RESP} state_t;

  state_t              state;
  logic [7:0]          cmd_q;
  logic [7:0]          arg_q;
  logic [7:0]          chk_q;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [8*NUM_CH-1:0] duty_q;
  logic [NUM_CH-1:0]   upd_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic [7:0]          err_q;
  logic                busy_q;

  logic [1:0] op;
  logic [5:0] ch;
  logic       ch_ok;
  logic       frame_ok;
  logic [7:0] rd_byte;
  logic       in_frame;
  logic       tmo_hit;
  logic       overrun;
  logic       err_ev;

  // Frame decode, readback mux and the error events seen this cycle
  always_comb begin
    op       = cmd_q[7:6];
    ch       = cmd_q[5:0];
    ch_ok    = {1'b0, ch} < 7'(NUM_CH);
    // Checksum first, then illegal opcode, then channel range (broadcast ignores channel)
    frame_ok = (chk_q == (SYNC_BYTE ^ cmd_q ^ arg_q)) && (op != 2'b11) &&
               ((op == 2'b01) || ch_ok);
    rd_byte  = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == 6'(k)) rd_byte = duty_q[8*k +: 8];
    end
    in_frame = (state == GET_CMD) || (state == GET_ARG) || (state == GET_CHK);
    // A byte arriving on the terminal count keeps the frame alive
    tmo_hit  = in_frame && !bus.rx_valid && (tmo_cnt == TMO_LAST);
    overrun  = bus.rx_valid && ((state == EXEC) || (state == RESP));
    // Coincident events collapse into a single increment
    err_ev   = tmo_hit || overrun || ((state == EXEC) && !frame_ok);
  end

  // Parser FSM with registered duty bank, response and error counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cmd_q      <= 8'h00;
      arg_q      <= 8'h00;
      chk_q      <= 8'h00;
      tmo_cnt    <= '0;
      duty_q     <= {NUM_CH{DUTY_INIT}};
      upd_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      upd_q <= '0;
      if (err_ev && (err_q != 8'hFF)) err_q <= err_q + 8'h01;

      case (state)
        IDLE: begin
          if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            state   <= GET_CMD;
            tmo_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end

        GET_CMD, GET_ARG, GET_CHK: begin
          if (bus.rx_valid) begin
            tmo_cnt <= '0;
            case (state)
              GET_CMD: begin cmd_q <= bus.rx_data; state <= GET_ARG; end
              GET_ARG: begin arg_q <= bus.rx_data; state <= GET_CHK; end
              default: begin chk_q <= bus.rx_data; state <= EXEC;    end
            endcase
          end else if (tmo_hit) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        EXEC: begin
          state      <= RESP;
          tx_valid_q <= 1'b1;
          if (!frame_ok) begin
            tx_data_q <= NAK;
          end else if (op == 2'b10) begin
            tx_data_q <= rd_byte;
          end else begin
            tx_data_q <= ACK;
            for (int k = 0; k < NUM_CH; k++) begin
              if ((op == 2'b01) || (ch == 6'(k))) begin
                duty_q[8*k +: 8] <= arg_q;
                upd_q[k]         <= 1'b1;
              end
            end
          end
        end

        RESP: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state      <= IDLE;
            busy_q     <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.duty        = duty_q;
  assign bus.duty_update = upd_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.err_count   = err_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_pwm_cmd_ctrl.sv
// tb/tb_pwm_cmd_ctrl.sv - directed and randomized frame stimulus against a byte-level behavioural model
module tb_pwm_cmd_ctrl;
  localparam int NCH = 4;
  localparam int T   = 40;  // timeout cycles: 1 MHz clock, 40 us

  logic CLK = 1'b0;
  logic RST = 1'b1;
  pwm_cmd_ctrl_if #(.NUM_CH(NCH)) bus();

  pwm_cmd_ctrl #(
    .CLK_FREQ(1_000_000), .NUM_CH(NCH), .DUTY_INIT(8'h40),
    .SYNC_BYTE(8'hA5), .TIMEOUT_US(T)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: frame progress as a byte count, outputs as plain values
  logic [7:0] m_duty [NCH];
  logic [NCH-1:0] m_upd;
  logic       m_txv;
  logic [7:0] m_txd;
  logic [7:0] m_err;
  int         m_ph;     // 0 idle, 1..3 frame bytes received, 4 executing, 5 responding
  int         m_gap;
  logic [7:0] m_fr [4];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(bit r, bit v, logic [7:0] d, bit t);
    bit ev;
    int op, ch;
    bit good;
    ev = 1'b0;
    if (r) begin
      for (int k = 0; k < NCH; k++) m_duty[k] = 8'h40;
      m_upd = '0; m_txv = 1'b0; m_txd = 8'h00; m_err = 8'h00; m_ph = 0; m_gap = 0;
      return;
    end
    m_upd = '0;
    if (m_ph == 0) begin
      if (v && d == 8'hA5) begin m_fr[0] = d; m_ph = 1; m_gap = 0; end
    end else if (m_ph <= 3) begin
      if (v) begin
        m_fr[m_ph] = d; m_ph++; m_gap = 0;
      end else begin
        m_gap++;
        if (m_gap >= T) begin m_ph = 0; ev = 1'b1; end
      end
    end else if (m_ph == 4) begin
      op   = int'(m_fr[1]) / 64;
      ch   = int'(m_fr[1]) % 64;
      good = (m_fr[3] == (m_fr[0] ^ m_fr[1] ^ m_fr[2])) && op != 3 && (op == 1 || ch < NCH);
      if (!good) begin
        m_txd = 8'h15; ev = 1'b1;
      end else if (op == 2) begin
        m_txd = m_duty[ch];
      end else begin
        m_txd = 8'h06;
        for (int k = 0; k < NCH; k++)
          if (op == 1 || k == ch) begin m_duty[k] = m_fr[2]; m_upd[k] = 1'b1; end
      end
      m_txv = 1'b1; m_ph = 5;
      if (v) ev = 1'b1;
    end else begin
      if (v) ev = 1'b1;
      if (t) begin m_txv = 1'b0; m_ph = 0; end
    end
    if (ev && m_err != 8'hFF) m_err = m_err + 8'h01;
  endtask

  // One clock of stimulus: apply inputs, advance the model, wait for the opposite edge
  task automatic cyc(bit r, bit v, logic [7:0] d, bit t);
    RST = r; bus.rx_valid = v; bus.rx_data = d; bus.tx_ready = t;
    model_step(r, v, d, t);
    @(negedge CLK);
  endtask

  task automatic idle(int n, bit t);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, t);
  endtask

  task automatic send(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3, bit t);
    cyc(1'b0, 1'b1, b0, t); cyc(1'b0, 1'b1, b1, t);
    cyc(1'b0, 1'b1, b2, t); cyc(1'b0, 1'b1, b3, t);
  endtask

  function automatic bit coin(int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  // Per-cycle comparison of every output against the model, just after the active edge
  always begin
    logic [8*NCH-1:0] mv;
    @(posedge CLK);
    #1;
    if (chk_en) begin
      for (int k = 0; k < NCH; k++) mv[8*k +: 8] = m_duty[k];
      check("duty",        64'(bus.duty),        64'(mv));
      check("duty_update", 64'(bus.duty_update), 64'(m_upd));
      check("tx_valid",    64'(bus.tx_valid),    64'(m_txv));
      check("tx_data",     64'(bus.tx_data),     64'(m_txd));
      check("err_count",   64'(bus.err_count),   64'(m_err));
      check("busy",        64'(bus.busy),        64'(m_ph != 0));
    end
  end

  initial begin
    #900_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    logic [7:0] fb [4];
    logic [7:0] cmd, arg;
    int g;
    chk_en = 1'b1;

    // Reset state
    cyc(1'b1, 1'b0, 8'h00, 1'b0); cyc(1'b1, 1'b0, 8'h00, 1'b0); cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_duty", 64'(bus.duty), 64'h40404040);
    check("rst_err",  64'(bus.err_count), 64'h0);
    check("rst_txv",  64'(bus.tx_valid), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);

    // Single-channel write, two cycles after the CHK strobe
    send(8'hA5, 8'h01, 8'h80, 8'h24, 1'b1); idle(1, 1'b1);
    check("t2_upd",   64'(bus.duty_update), 64'h2);
    check("t2_duty",  64'(bus.duty), 64'h40408040);
    check("t2_txd",   64'(bus.tx_data), 64'h06);
    check("t2_txv",   64'(bus.tx_valid), 64'h1);
    check("t2_model", 64'(m_duty[1]), 64'h80);
    idle(1, 1'b1);
    check("t2_upd_off", 64'(bus.duty_update), 64'h0);
    check("t2_txv_off", 64'(bus.tx_valid), 64'h0);

    // Broadcast write
    send(8'hA5, 8'h40, 8'hFF, 8'h1A, 1'b1); idle(1, 1'b1);
    check("t3_duty", 64'(bus.duty), 64'hFFFFFFFF);
    check("t3_upd",  64'(bus.duty_update), 64'hF);
    check("t3_txd",  64'(bus.tx_data), 64'h06);
    idle(1, 1'b1);

    // Bad checksum, then channel out of range
    send(8'hA5, 8'h01, 8'h80, 8'h00, 1'b1); idle(1, 1'b1);
    check("t4_nak", 64'(bus.tx_data), 64'h15);
    check("t4_upd", 64'(bus.duty_update), 64'h0);
    idle(1, 1'b1);
    check("t4_err1", 64'(bus.err_count), 64'h1);
    check("t4_duty", 64'(bus.duty), 64'hFFFFFFFF);
    send(8'hA5, 8'h05, 8'h10, 8'hB0, 1'b1); idle(2, 1'b1);
    check("t4_err2",   64'(bus.err_count), 64'h2);
    check("t4_model2", 64'(m_err), 64'h2);

    // Readback held under backpressure, with overrun bytes
    send(8'hA5, 8'h01, 8'h80, 8'h24, 1'b1); idle(2, 1'b1);
    send(8'hA5, 8'h81, 8'h00, 8'h24, 1'b0); idle(1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, (i % 3) == 1, 8'h33, 1'b0);
      check("t5_txv", 64'(bus.tx_valid), 64'h1);
      check("t5_txd", 64'(bus.tx_data), 64'h80);
    end
    idle(1, 1'b1);
    check("t5_txv_done", 64'(bus.tx_valid), 64'h0);
    check("t5_busy",     64'(bus.busy), 64'h0);
    check("t5_err",      64'(bus.err_count), 64'h5);

    // Timeout mid-frame, then recovery
    cyc(1'b0, 1'b1, 8'hA5, 1'b1); cyc(1'b0, 1'b1, 8'h01, 1'b1); idle(T + 5, 1'b1);
    check("t6_busy", 64'(bus.busy), 64'h0);
    check("t6_err",  64'(bus.err_count), 64'h6);
    check("t6_txv",  64'(bus.tx_valid), 64'h0);
    send(8'hA5, 8'h02, 8'h55, 8'hF2, 1'b1); idle(1, 1'b1);
    check("t6_duty2", 64'(bus.duty[23:16]), 64'h55);
    check("t6_ack",   64'(bus.tx_data), 64'h06);
    idle(1, 1'b1);

    // Byte on the terminal count wins
    cyc(1'b0, 1'b1, 8'hA5, 1'b1); cyc(1'b0, 1'b1, 8'h03, 1'b1); idle(T - 1, 1'b1);
    cyc(1'b0, 1'b1, 8'h77, 1'b1); cyc(1'b0, 1'b1, 8'hD1, 1'b1); idle(1, 1'b1);
    check("tb_duty3", 64'(bus.duty[31:24]), 64'h77);
    check("tb_err",   64'(bus.err_count), 64'h6);
    idle(1, 1'b1);

    // Exactly T silent cycles times out
    cyc(1'b0, 1'b1, 8'hA5, 1'b1); cyc(1'b0, 1'b1, 8'h04, 1'b1); idle(T, 1'b1);
    check("tt_busy", 64'(bus.busy), 64'h0);
    check("tt_err",  64'(bus.err_count), 64'h7);

    // Reset mid-frame
    cyc(1'b0, 1'b1, 8'hA5, 1'b1); cyc(1'b0, 1'b1, 8'h01, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1); cyc(1'b0, 1'b1, 8'h80, 1'b1);
    cyc(1'b0, 1'b1, 8'h24, 1'b1); idle(3, 1'b1);
    check("rm_duty", 64'(bus.duty), 64'h40404040);
    check("rm_txv",  64'(bus.tx_valid), 64'h0);
    check("rm_err",  64'(bus.err_count), 64'h0);

    // Randomized frames, gaps, backpressure, overruns and resets
    for (int f = 0; f < 250; f++) begin
      if (coin(3)) begin
        cyc(1'b1, 1'b0, 8'h00, 1'b0); cyc(1'b1, 1'b0, 8'h00, 1'b0);
        continue;
      end
      cmd = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 5))};
      arg = 8'($urandom);
      fb[0] = coin(6) ? 8'($urandom) : 8'hA5;
      fb[1] = cmd;
      fb[2] = arg;
      fb[3] = 8'hA5 ^ cmd ^ arg;
      if (coin(12)) fb[3] = fb[3] ^ (8'h01 << $urandom_range(0, 7));
      for (int i = 0; i < 4; i++) begin
        cyc(1'b0, 1'b1, fb[i], coin(50));
        if (i < 3) begin
          if (coin(3)) g = T - 1;
          else if (coin(3)) g = T + $urandom_range(0, 2);
          else g = $urandom_range(0, 3);
          for (int j = 0; j < g; j++) cyc(1'b0, 1'b0, 8'($urandom), coin(50));
        end
      end
      for (int w = 0; w < 120 && m_ph != 0; w++) cyc(1'b0, coin(10), 8'($urandom), coin(40));
    end
    idle(4, 1'b1);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
